// File: rtl/div_seq_dual.sv
// Radix-2 sequential divider, restoring or non-restoring per operation.
// Optional early termination when |dividend| < |divisor|: DIV_EARLY_TERM_EN.
module div_seq_dual #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         alg_sel,
  input  logic         signed_en,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         ready,
  output logic         busy,
  output logic         dbz,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          alg_q;
  logic          skip_q;
  logic          qneg_q;
  logic          rneg_q;
  logic          ovf_q;
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  qr_q;
  logic [N:0]    pr_q;

  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b;
  logic          is_ovf;
  logic          early;

  logic [N+1:0]  sh;
  logic [N+1:0]  dx;
  logic [N+1:0]  trial;
  logic [N:0]    pr_nx;
  logic          q_bit;
  logic [N-1:0]  r_mag;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;

  // Operand magnitudes and acceptance-time decisions
  always_comb begin
    mag_a = (signed_en && dividend[N-1]) ? -dividend : dividend;
    mag_b = (signed_en && divisor[N-1]) ? -divisor : divisor;
    is_ovf = signed_en && (dividend == MIN_NEG) && (&divisor);
`ifdef DIV_EARLY_TERM_EN
    early = (divisor != '0) && (mag_a < mag_b);
`else
    early = 1'b0;
`endif
  end

  // One radix-2 step; restoring never holds a negative remainder
  always_comb begin
    sh    = {pr_q, qr_q[N-1]};
    dx    = {2'b00, dvs_q};
    trial = (alg_q && pr_q[N]) ? sh + dx : sh - dx;
    pr_nx = trial[N:0];
    q_bit = ~trial[N+1];
    if (!alg_q && trial[N+1]) begin
      pr_nx = sh[N:0];
      q_bit = 1'b0;
    end
  end

  // Final remainder correction and sign application
  always_comb begin
    r_mag = pr_q[N] ? (pr_q[N-1:0] + dvs_q) : pr_q[N-1:0];
    q_fin = qneg_q ? -qr_q : qr_q;
    r_fin = rneg_q ? -r_mag : r_mag;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      alg_q     <= 1'b0;
      skip_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dvs_q     <= '0;
      qr_q      <= '0;
      pr_q      <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            alg_q  <= alg_sel;
            dbz    <= 1'b0;
            ovf    <= 1'b0;
            qneg_q <= signed_en & (dividend[N-1] ^ divisor[N-1]);
            rneg_q <= signed_en & dividend[N-1];
            ovf_q  <= is_ovf;
            dvs_q  <= mag_b;
            qr_q   <= mag_a;
            pr_q   <= '0;
            skip_q <= 1'b0;
            // Short-circuit results land now; FIX only pads the latency
            unique case (1'b1)
              (divisor == '0): begin
                quotient  <= '1;
                remainder <= dividend;
                dbz       <= 1'b1;
                skip_q    <= 1'b1;
                state     <= S_FIX;
              end
              early: begin
                quotient  <= '0;
                remainder <= dividend;
                skip_q    <= 1'b1;
                state     <= S_FIX;
              end
              default: begin
                cnt   <= CW'(N);
                state <= S_ITER;
              end
            endcase
          end
        end
        S_ITER: begin
          pr_q <= pr_nx;
          qr_q <= {qr_q[N-2:0], q_bit};
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (!skip_q) begin
            if (ovf_q) begin
              quotient  <= MIN_NEG;
              remainder <= '0;
              ovf       <= 1'b1;
            end else begin
              quotient  <= q_fin;
              remainder <= r_fin;
            end
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status decoded straight from the state register
  always_comb begin
    ready = (state == S_DONE);
    busy  = (state != S_IDLE);
  end

endmodule

// File: tb/tb_div_seq_dual.sv
// Scoreboard bench for div_seq_dual (N=8).
// Driver queues expectations; a negedge monitor checks each ready pulse.
module tb_div_seq_dual;

  localparam int N    = 8;
  localparam int LATN = N + 1;
  localparam int LATS = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         alg_sel;
  logic         signed_en;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         ready;
  logic         busy;
  logic         dbz;
  logic         ovf;

  div_seq_dual #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alg_sel   (alg_sel),
    .signed_en (signed_en),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .busy      (busy),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  typedef struct {
    string        name;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
    int           e0;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        me = sb.pop_front();
        chk({me.name, "_q"}, 32'(quotient), 32'(me.q));
        chk({me.name, "_r"}, 32'(remainder), 32'(me.r));
        chk({me.name, "_dbz"}, 32'(dbz), 32'(me.dbz));
        chk({me.name, "_ovf"}, 32'(ovf), 32'(me.ovf));
        chk({me.name, "_lat"}, 32'(ec - me.e0), 32'(me.lat));
        chk({me.name, "_busy"}, 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_done(input string nm, input bit poke);
    bit seen = 0;
    int nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1;
        break;
      end
      if (!busy) nb++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=0 required=1", nm);
    end
    chk({nm, "_busy_hold"}, 32'(nb), 32'd0);
    if (poke) begin
      start    = 1'b1;
      dividend = 8'd9;
      divisor  = 8'd2;
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_pulse"}, 32'(ready), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic issue(input string nm, input bit alg, input bit sgn,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] q, input logic [N-1:0] r,
                       input bit edbz, input bit eovf, input int lat,
                       input bit inj);
    exp_t e;
    @(negedge clk);
    alg_sel   = alg;
    signed_en = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e.name = nm;
    e.q    = q;
    e.r    = r;
    e.dbz  = edbz;
    e.ovf  = eovf;
    e.lat  = lat;
    e.e0   = ec;
    sb.push_back(e);
    start = 1'b0;
    if (inj) begin
      repeat (2) @(posedge clk);
      #1;
      start    = 1'b1;
      alg_sel  = ~alg;
      dividend = 8'd50;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(nm, inj);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    alg_sel   = 1'b0;
    signed_en = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({ready, busy, dbz, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int alg = 0; alg < 2; alg++) begin
      issue("u115_7", alg[0], 0, 8'd115, 8'd7, 8'd16, 8'd3, 0, 0, LATN, 0);
      issue("u11_3", alg[0], 0, 8'd11, 8'd3, 8'd3, 8'd2, 0, 0, LATN, 0);
      issue("u200_13", alg[0], 0, 8'd200, 8'd13, 8'd15, 8'd5, 0, 0, LATN, 0);
      issue("sm7_2", alg[0], 1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0, LATN, 0);
      issue("s7_m2", alg[0], 1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 0, LATN, 0);
      issue("sovf", alg[0], 1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1, LATN, 0);
    end

    issue("dbz42", 0, 0, 8'd42, 8'd0, 8'hFF, 8'd42, 1, 0, LATS, 0);
    issue("u113_19", 1, 0, 8'd113, 8'd19, 8'd5, 8'd18, 0, 0, LATN, 0);
    issue("ign200_13", 1, 0, 8'd200, 8'd13, 8'd15, 8'd5, 0, 0, LATN, 1);
    chk("ign_not_taken", 32'(busy), 32'd0);
    issue("after_ign", 0, 0, 8'd11, 8'd3, 8'd3, 8'd2, 0, 0, LATN, 0);

    @(negedge clk);
    alg_sel   = 1'b0;
    signed_en = 1'b0;
    dividend  = 8'd115;
    divisor   = 8'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_q", 32'(quotient), 32'd0);
    chk("arst_r", 32'(remainder), 32'd0);
    chk("arst_flags", 32'({ready, busy, dbz, ovf}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_quiet", 32'(busy), 32'd0);
    issue("post_rst", 0, 0, 8'd115, 8'd7, 8'd16, 8'd3, 0, 0, LATN, 0);

`ifdef DIV_EARLY_TERM_EN
    issue("u3_19", 0, 0, 8'd3, 8'd19, 8'd0, 8'd3, 0, 0, LATS, 0);
    issue("u3_19n", 1, 0, 8'd3, 8'd19, 8'd0, 8'd3, 0, 0, LATS, 0);
`else
    issue("u3_19", 0, 0, 8'd3, 8'd19, 8'd0, 8'd3, 0, 0, LATN, 0);
    issue("u3_19n", 1, 0, 8'd3, 8'd19, 8'd0, 8'd3, 0, 0, LATN, 0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
